dmem_write_tap: RTL and testbench

- Snoops the processor-to-data-memory write bus, downstream of the D-cache memory port.
- Turns each completed store into exactly one event, even when `mem_wen` is held high across cache stalls.
- Buffers events in a small first-word-fall-through FIFO.
- The result-checking stage pops events with a valid/ready handshake, so the checker never needs its own stall-filtering logic.

---
 rtl/dmem_write_tap.sv | 112 +++++++++++
 tb/tb_dmem_write_tap.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_tap.sv
// Snoops the D-side memory write bus and turns each completed store into one event in a small FWFT FIFO.
// Detect-to-visible latency is one cycle. The consumer pops with out_valid/out_ready. Events arriving while the FIFO is full are dropped and counted.
module dmem_write_tap #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_wen,
   input  logic              mem_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [PTR_W:0]    count,
   output logic [7:0]        overflow_cnt,
   output logic [15:0]       write_total
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   last_addr_q;
   logic                detect;

   logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
   logic [DATA_W-1:0]   data_mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]      count_q, count_d;
   logic [7:0]          overflow_q;
   logic [15:0]         total_q;
   logic                full, pop, push, drop;

   // A held request at the last detected address is a stall, not a new store.
   always_comb begin
      state_d = state_q;
      detect  = 1'b0;
      if (!mem_wen) begin
         state_d = IDLE;
      end else if (state_q == DONE && mem_addr == last_addr_q) begin
         state_d = DONE;
      end else if (mem_ready) begin
         detect  = 1'b1;
         state_d = DONE;
      end else begin
         state_d = WAIT_ACK;
      end
   end

   assign full      = (count_q == FULL_CNT);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = detect && (!full || pop);
   assign drop      = detect && full && !pop;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= '0;
         total_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (detect) begin
            last_addr_q <= mem_addr;
            total_q     <= total_q + 16'd1;
         end
         if (push) begin
            addr_mem_q[wr_ptr_q] <= mem_addr;
            data_mem_q[wr_ptr_q] <= mem_wdata;
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (drop && overflow_q != 8'hFF) begin
            overflow_q <= overflow_q + 8'd1;
         end
      end
   end

   // Gate the head with valid so stale entries never leak out once drained.
   assign out_addr     = out_valid ? addr_mem_q[rd_ptr_q] : '0;
   assign out_data     = out_valid ? data_mem_q[rd_ptr_q] : '0;
   assign count        = count_q;
   assign overflow_cnt = overflow_q;
   assign write_total  = total_q;

endmodule

// File: tb/tb_dmem_write_tap.sv
// Directed bench for dmem_write_tap with a scoreboard queue of expected {addr, data} events.
module tb_dmem_write_tap;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wen;
   logic        mem_ready;
   logic        out_valid;
   logic [29:0] out_addr;
   logic [31:0] out_data;
   logic        out_ready;
   logic [2:0]  count;
   logic [7:0]  overflow_cnt;
   logic [15:0] write_total;

   int checks = 0;
   int errors = 0;
   int exp_wt = 0;
   int exp_ovf = 0;
   logic [61:0] sb[$];

   always #5 clk = ~clk;

   dmem_write_tap dut (
      .clk(clk), .rst(rst),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ready(mem_ready),
      .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
      .count(count), .overflow_cnt(overflow_cnt), .write_total(write_total)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [29:0] a, input logic [31:0] d, input logic w, input logic r);
      mem_addr  = a;
      mem_wdata = d;
      mem_wen   = w;
      mem_ready = r;
   endtask

   // Pops everything the scoreboard expects, comparing each head, then confirms empty.
   task automatic drain(input string tag);
      logic [61:0] e;
      int budget;
      budget = 20;
      out_ready = 1'b1;
      while (sb.size() != 0 && budget > 0) begin
         if (out_valid) begin
            e = sb.pop_front();
            chk({tag, "_addr"}, 64'(out_addr), 64'(e[61:32]));
            chk({tag, "_data"}, 64'(out_data), 64'(e[31:0]));
         end
         tick();
         budget--;
      end
      if (budget == 0) chk({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      chk({tag, "_empty"}, 64'(out_valid), 64'd0);
      chk({tag, "_cnt0"}, 64'(count), 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      out_ready = 1'b0;
      drive(30'd0, 32'd0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ovf", 64'(overflow_cnt), 64'd0);
      chk("rst_wt", 64'(write_total), 64'd0);
      chk("rst_addr", 64'(out_addr), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      rst = 1'b1;
      tick();

      // 1: single store, no stall
      drive(30'd0, 32'd5, 1'b1, 1'b1);
      sb.push_back({30'd0, 32'd5}); exp_wt++;
      tick();
      drive(30'd0, 32'd0, 1'b0, 1'b0);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_addr", 64'(out_addr), 64'd0);
      chk("t1_data", 64'(out_data), 64'd5);
      chk("t1_count", 64'(count), 64'd1);
      chk("t1_wt", 64'(write_total), 64'(exp_wt));
      drain("t1");

      // 2: stalled store, consumer already ready (no bypass)
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(30'd1, 32'd4, 1'b1, 1'b0);
         tick();
         chk("t2_stall_cnt", 64'(count), 64'd0);
      end
      drive(30'd1, 32'd4, 1'b1, 1'b1);
      sb.push_back({30'd1, 32'd4}); exp_wt++;
      tick();
      drive(30'd1, 32'd4, 1'b0, 1'b0);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_count", 64'(count), 64'd1);
      chk("t2_wt", 64'(write_total), 64'(exp_wt));
      drain("t2");

      // 3: held wen with ready high, then address change while held
      for (int i = 0; i < 5; i++) begin
         drive(30'd2, 32'h22, 1'b1, 1'b1);
         if (i == 0) begin sb.push_back({30'd2, 32'h22}); exp_wt++; end
         tick();
      end
      chk("t3_hold_cnt", 64'(count), 64'd1);
      drive(30'd3, 32'h33, 1'b1, 1'b1);
      sb.push_back({30'd3, 32'h33}); exp_wt++;
      tick();
      drive(30'd3, 32'h33, 1'b0, 1'b0);
      chk("t3_count", 64'(count), 64'd2);
      chk("t3_wt", 64'(write_total), 64'(exp_wt));
      drain("t3");

      // 4: overflow with six back-to-back stores
      for (int i = 0; i < 6; i++) begin
         drive(30'(i), 32'(100 + i), 1'b1, 1'b1);
         if (i < 4) sb.push_back({30'(i), 32'(100 + i)});
         else exp_ovf++;
         exp_wt++;
         tick();
      end
      drive(30'd0, 32'd0, 1'b0, 1'b0);
      chk("t4_count", 64'(count), 64'd4);
      chk("t4_ovf", 64'(overflow_cnt), 64'(exp_ovf));
      chk("t4_wt", 64'(write_total), 64'(exp_wt));
      tick();
      chk("t4_hold_addr", 64'(out_addr), 64'd0);
      drain("t4");

      // 5: full FIFO, push and pop in the same cycle
      for (int i = 0; i < 4; i++) begin
         drive(30'(i), 32'(200 + i), 1'b1, 1'b1);
         sb.push_back({30'(i), 32'(200 + i)}); exp_wt++;
         tick();
      end
      drive(30'd0, 32'd0, 1'b0, 1'b0);
      tick();
      chk("t5_full", 64'(count), 64'd4);
      out_ready = 1'b1;
      drive(30'd9, 32'd909, 1'b1, 1'b1);
      begin
         logic [61:0] e;
         e = sb.pop_front();
         chk("t5_head", 64'(out_addr), 64'(e[61:32]));
      end
      sb.push_back({30'd9, 32'd909}); exp_wt++;
      tick();
      out_ready = 1'b0;
      drive(30'd9, 32'd909, 1'b0, 1'b0);
      chk("t5_count", 64'(count), 64'd4);
      chk("t5_ovf", 64'(overflow_cnt), 64'(exp_ovf));
      chk("t5_wt", 64'(write_total), 64'(exp_wt));
      drain("t5");

      // 6: asynchronous reset with data buffered and a request pending
      for (int i = 0; i < 3; i++) begin
         drive(30'(40 + i), 32'(i), 1'b1, 1'b1);
         tick();
      end
      drive(30'd7, 32'd77, 1'b1, 1'b0);
      tick();
      chk("t6_pre_cnt", 64'(count), 64'd3);
      #2 rst = 1'b0;
      #1;
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_ovf", 64'(overflow_cnt), 64'd0);
      chk("t6_wt", 64'(write_total), 64'd0);
      chk("t6_addr", 64'(out_addr), 64'd0);
      sb.delete();
      exp_wt = 0;
      @(negedge clk);
      drive(30'd7, 32'd77, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      tick();
      chk("t6_no_evt_cnt", 64'(count), 64'd0);
      chk("t6_no_evt_wt", 64'(write_total), 64'd0);
      drive(30'hA, 32'hAA, 1'b1, 1'b1);
      sb.push_back({30'hA, 32'hAA}); exp_wt++;
      tick();
      drive(30'hA, 32'hAA, 1'b0, 1'b0);
      chk("t6_new_wt", 64'(write_total), 64'(exp_wt));
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
